// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory-port bundle: request side driven by the CPU, response side by the responder.
interface mem_responder_if;

  logic        req;
  logic        wr;
  logic [31:0] Address;
  logic [31:0] WriteDataMem;
  logic [31:0] MemData;
  logic        ready;
  logic        misaligned;
  logic        busy;

  modport master (
    output req, wr, Address, WriteDataMem,
    input  MemData, ready, misaligned, busy
  );

  modport slave (
    input  req, wr, Address, WriteDataMem,
    output MemData, ready, misaligned, busy
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, read-first, no reset on contents.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           Clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    din,
  output logic [31:0]                    dout
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write on we; the registered read returns the word as it was before this edge.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem_q[idx] <= din;
    end
    dout <= mem_q[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request, waits WAIT_STATES cycles, performs the
// array access, then pulses ready with registered read data and misalignment flag.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic           Clk,
  input  logic           reset,
  mem_responder_if.slave bus_io
);

  localparam int unsigned OffW     = $clog2(WORD_BYTES);
  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam cnt_t        WaitLoad = cnt_t'(WAIT_STATES);

  mem_state_t     state_q;
  cnt_t           cnt_q;
  logic [31:0]    addr_q, wdata_q, rdata_q;
  logic           wr_q, ready_q, mis_q, busy_q;

  logic           access, acc_wr, acc_aligned, ram_we;
  logic [31:0]    acc_addr, acc_wdata, ram_dout;
  logic [IdxW-1:0] ram_idx;
  logic           unused_addr;

  // Pick the access source: a zero-wait accept uses the live request, otherwise the latched one.
  always_comb begin
    access = 1'b0;
    if (state_q == StIdle) begin
      acc_addr  = bus_io.Address;
      acc_wr    = bus_io.wr;
      acc_wdata = bus_io.WriteDataMem;
      access    = bus_io.req && (WAIT_STATES == 0);
    end else begin
      acc_addr  = addr_q;
      acc_wr    = wr_q;
      acc_wdata = wdata_q;
      access    = (state_q == StWait) && (cnt_q == cnt_t'(1));
    end
    acc_aligned = (acc_addr[OffW-1:0] == '0);
    // Gate with reset so a reset landing on the access edge never commits a write.
    ram_we      = reset && access && acc_wr && acc_aligned;
    ram_idx     = acc_addr[IdxW+OffW-1:OffW];
    // Upper address bits are deliberately dropped so addresses wrap modulo the depth.
    unused_addr = ^acc_addr[31:IdxW+OffW];
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .Clk  (Clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .din  (acc_wdata),
    .dout (ram_dout)
  );

  // Request FSM with latches, wait counter and registered outputs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      if (ready_q) begin
        busy_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (bus_io.req) begin
            addr_q  <= bus_io.Address;
            wr_q    <= bus_io.wr;
            wdata_q <= bus_io.WriteDataMem;
            cnt_q   <= WaitLoad;
            busy_q  <= 1'b1;
            state_q <= (WAIT_STATES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - cnt_t'(1);
          if (cnt_q == cnt_t'(1)) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          // The RAM read issued on the access edge is valid now; capture it with ready.
          ready_q <= 1'b1;
          mis_q   <= (addr_q[OffW-1:0] != '0);
          if (!wr_q && (addr_q[OffW-1:0] == '0)) begin
            rdata_q <= ram_dout;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.MemData    = rdata_q;
  assign bus_io.ready      = ready_q;
  assign bus_io.misaligned = mis_q;
  assign bus_io.busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder across four wait-state configurations.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_n;
  int          sel;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic        ready, mis, busy;
  logic [31:0] rdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  mem_responder_if bus2 ();
  mem_responder_if bus3 ();

  assign bus0.req = req && (sel == 0);
  assign bus1.req = req && (sel == 1);
  assign bus2.req = req && (sel == 2);
  assign bus3.req = req && (sel == 3);
  assign bus0.wr = wr;
  assign bus1.wr = wr;
  assign bus2.wr = wr;
  assign bus3.wr = wr;
  assign bus0.Address = addr;
  assign bus1.Address = addr;
  assign bus2.Address = addr;
  assign bus3.Address = addr;
  assign bus0.WriteDataMem = wdata;
  assign bus1.WriteDataMem = wdata;
  assign bus2.WriteDataMem = wdata;
  assign bus3.WriteDataMem = wdata;

  always_comb begin
    case (sel)
      0: begin ready = bus0.ready; mis = bus0.misaligned; busy = bus0.busy; rdata = bus0.MemData; end
      1: begin ready = bus1.ready; mis = bus1.misaligned; busy = bus1.busy; rdata = bus1.MemData; end
      2: begin ready = bus2.ready; mis = bus2.misaligned; busy = bus2.busy; rdata = bus2.MemData; end
      default: begin
        ready = bus3.ready; mis = bus3.misaligned; busy = bus3.busy; rdata = bus3.MemData;
      end
    endcase
  end

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1))  u0 (.Clk(clk), .reset(rst_n[0]), .bus_io(bus0));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3))  u1 (.Clk(clk), .reset(rst_n[1]), .bus_io(bus1));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0))  u2 (.Clk(clk), .reset(rst_n[2]), .bus_io(bus2));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(15)) u3 (.Clk(clk), .reset(rst_n[3]), .bus_io(bus3));

  // One access on instance k; inputs are scrambled right after the accept edge.
  // lat counts cycles from the accept edge to the first sample showing ready (-1 on timeout).
  task automatic do_acc(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic m,
                        output logic busy_mid, output logic busy_after);
    @(negedge clk);
    sel = k; req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk);
    lat = -1; rd = '0; m = 1'b0; busy_mid = 1'b0; busy_after = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin
        req = 1'b0; wr = ~w; addr = ~a; wdata = ~d; busy_mid = busy;
      end
      if (ready) begin
        lat = n; rd = rdata; m = mis;
        break;
      end
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic m, bm, ba;
    sel = 0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_initial: busy=%0b ready=%0b MemData=%h required 0/0/0", busy, ready, rdata);
    end
    // Word 0 stands in for preloaded content; it must survive a reset.
    do_acc(0, 1'b1, 32'h0, 32'h1122_3344, lat, rd, m, bm, ba);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL reset_prime_lat: got %0d required 2", lat); end
    do_acc(0, 1'b0, 32'h0, 32'h0, lat, rd, m, bm, ba);
    n_tests++;
    if (rd !== 32'h1122_3344) begin
      n_fail++; $display("FAIL reset_prime_read: got %h required 11223344", rd);
    end
    // Reset in the middle of a read.
    @(negedge clk);
    sel = 0; req = 1'b1; wr = 1'b0; addr = 32'h4;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    n_tests++;
    if (ready !== 1'b0 || mis !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%0b mis=%0b busy=%0b MemData=%h required all 0",
               ready, mis, busy, rdata);
    end
    n_tests++;
    if (u0.state_q !== StIdle) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", u0.state_q, StIdle);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    do_acc(0, 1'b0, 32'h0, 32'h0, lat, rd, m, bm, ba);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL reset_read_lat: got %0d required 2", lat); end
    n_tests++;
    if (rd !== 32'h1122_3344) begin
      n_fail++; $display("FAIL reset_read_data: got %h required 11223344", rd);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic m, bm, ba;
    do_acc(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, m, bm, ba);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL wr_lat: got %0d required 2", lat); end
    n_tests++;
    if (m !== 1'b0) begin n_fail++; $display("FAIL wr_mis: got %0b required 0", m); end
    n_tests++;
    if (bm !== 1'b1 || ba !== 1'b0) begin
      n_fail++; $display("FAIL wr_busy: mid=%0b after=%0b required 1/0", bm, ba);
    end
    do_acc(0, 1'b0, 32'h10, 32'h0, lat, rd, m, bm, ba);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL rd_lat: got %0d required 2", lat); end
    n_tests++;
    if (rd !== 32'hDEAD_BEEF || m !== 1'b0) begin
      n_fail++; $display("FAIL rd_data: got %h mis=%0b required deadbeef mis=0", rd, m);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic m, bm, ba;
    do_acc(0, 1'b1, 32'h13, 32'h1234_5678, lat, rd, m, bm, ba);
    n_tests++;
    if (lat !== 2 || m !== 1'b1) begin
      n_fail++; $display("FAIL mis_wr: lat=%0d mis=%0b required 2/1", lat, m);
    end
    do_acc(0, 1'b0, 32'h10, 32'h0, lat, rd, m, bm, ba);
    n_tests++;
    if (rd !== 32'hDEAD_BEEF || m !== 1'b0) begin
      n_fail++; $display("FAIL mis_wr_nocommit: got %h mis=%0b required deadbeef mis=0", rd, m);
    end
    do_acc(0, 1'b0, 32'h0, 32'h0, lat, rd, m, bm, ba);
    n_tests++;
    if (rd !== 32'h1122_3344) begin
      n_fail++; $display("FAIL mis_prep_read: got %h required 11223344", rd);
    end
    // A misaligned read completes but leaves MemData alone.
    do_acc(0, 1'b0, 32'h11, 32'h0, lat, rd, m, bm, ba);
    n_tests++;
    if (rd !== 32'h1122_3344 || m !== 1'b1 || lat !== 2) begin
      n_fail++;
      $display("FAIL mis_rd: got %h mis=%0b lat=%0d required 11223344 mis=1 lat=2", rd, m, lat);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic m, bm, ba;
    do_acc(0, 1'b1, 32'h400, 32'hA5A5_A5A5, lat, rd, m, bm, ba);
    do_acc(0, 1'b0, 32'h000, 32'h0, lat, rd, m, bm, ba);
    n_tests++;
    if (rd !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL wrap: got %h required a5a5a5a5", rd);
    end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic m, bm, ba;
    logic seen;
    do_acc(1, 1'b1, 32'h20, 32'h0BAD_F00D, lat, rd, m, bm, ba);
    n_tests++;
    if (lat !== 4) begin n_fail++; $display("FAIL abort_prior_lat: got %0d required 4", lat); end
    @(negedge clk);
    sel = 1; req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: busy=%0b ready=%0b required 0/0", busy, ready);
    end
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 0) rst_n[1] = 1'b1;
      seen = seen | ready;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %0b required 0", seen); end
    do_acc(1, 1'b0, 32'h20, 32'h0, lat, rd, m, bm, ba);
    n_tests++;
    if (rd !== 32'h0BAD_F00D || lat !== 4) begin
      n_fail++; $display("FAIL abort_read: got %h lat=%0d required 0badf00d lat=4", rd, lat);
    end
  endtask

  task automatic test_back_to_back(input int k, input int ws, input int gap);
    int lat; logic [31:0] rd; logic m, bm, ba;
    int t [3];
    int np;
    logic [31:0] exp_d;
    exp_d = 32'h600D_CAFE ^ k;
    do_acc(k, 1'b1, 32'h8, exp_d, lat, rd, m, bm, ba);
    n_tests++;
    if (lat !== ws + 1) begin
      n_fail++; $display("FAIL b2b%0d_lat: got %0d required %0d", k, lat, ws + 1);
    end
    @(negedge clk);
    sel = k; req = 1'b1; wr = 1'b0; addr = 32'h8;
    np = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (ready) begin
        t[np] = n;
        n_tests++;
        if (rdata !== exp_d) begin
          n_fail++; $display("FAIL b2b%0d_data%0d: got %h required %h", k, np, rdata, exp_d);
        end
        np++;
        if (np == 3) begin
          req = 1'b0;
          break;
        end
      end
    end
    n_tests++;
    if (np !== 3) begin
      n_fail++; $display("FAIL b2b%0d_pulses: got %0d required 3", k, np);
    end else begin
      n_tests++;
      if (t[1] - t[0] !== gap || t[2] - t[1] !== gap) begin
        n_fail++;
        $display("FAIL b2b%0d_gap: got %0d,%0d required %0d", k, t[1] - t[0], t[2] - t[1], gap);
      end
    end
    repeat (ws + 4) @(negedge clk);
  endtask

  initial begin
    rst_n = '0; sel = 0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = '1;
    test_reset();
    test_write_read();
    test_misaligned();
    test_wrap();
    test_abort();
    test_back_to_back(2, 0, 2);
    test_back_to_back(3, 15, 17);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data/instruction memory responder that services the multicycle CPU's memory port with a request/ready handshake and a programmable number of wait states. It sits between the CPU datapath's address mux (PC or ALUOut) and a single-port storage array. It latches each request, stalls for a fixed latency, then returns read data or commits write data. Misaligned accesses are reported to the CPU so it can raise an exception (EPC capture) instead of corrupting memory.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, minimum 4.
- `WAIT_STATES`, default 1: extra cycles between accept and response; range 0–15.

Ports:
- `Clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: access request. Held by the CPU until `ready`.
- `wr` in 1: 1 = write, 0 = read. Sampled with `req`.
- `Address` in 32: byte address.
- `WriteDataMem` in 32: write data.
- `MemData` out 32: read data. Holds its last read value.
- `ready` out 1: one-cycle completion pulse.
- `misaligned` out 1: qualifies `ready`. High when `Address[1:0]` of the accepted request was nonzero.
- `busy` out 1: high from accept until the cycle after `ready`.

## Operation
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - With `req`=1 at a rising edge, the request is accepted and `Address`, `wr` and `WriteDataMem` are latched. Later input changes are ignored.
  - On accept, the wait counter loads `WAIT_STATES`. Next state is WAIT if `WAIT_STATES`>0, else RESP.
- WAIT: the counter decrements each cycle. On the edge where it reaches 0, the FSM performs the access and moves to RESP.
- Access:
  - The word index is `Address[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so out-of-range addresses wrap modulo the depth.
  - Read: the array word is registered into `MemData`.
  - Write: the array word is overwritten. `MemData` is unchanged.
  - Misaligned (latched `Address[1:0]`≠0): no array write and no `MemData` update. The access still completes.
- RESP:
  - `ready`=1 for exactly one cycle. `misaligned` reflects the latched address.
  - Next state is always IDLE. `req` is ignored during RESP.
  - A `req` still high in the following IDLE cycle is a new request.
- Outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values: FSM IDLE, counter 0, `MemData`=0, `ready`=0, `misaligned`=0, `busy`=0. Array contents are not cleared by reset.
- Latency: `ready` is asserted `WAIT_STATES`+1 cycles after the accept edge.
- Throughput: at most one access per `WAIT_STATES`+2 cycles.
- `busy` rises on the accept edge and falls on the edge after `ready`.
- Reset during WAIT: the access is aborted, nothing is written, and no `ready` is issued.
- Reset asserted on the same edge as the access: reset wins, and array and `MemData` are unchanged.
- `misaligned` is 0 whenever `ready` is 0.
- Read-after-write to the same word returns the new data.

## Structure
- Package `mem_pkg` holds:
  - the `mem_state_t` enum (IDLE, WAIT, RESP);
  - `WORD_BYTES`=4;
  - the width of the wait counter (4 bits).
- Sub-module `mem_array` is a single-port synchronous RAM: `Clk`, `we`, `idx`, `din`, `dout`, with no reset. It is optionally preloaded from a hex file for simulation.
- FSM, latches and counter live in `mem_responder`.

## Test plan
- Reset state: assert `reset`=0 mid-run → all outputs 0 and state IDLE. Release, then issue `req`=1 `wr`=0 `Address`=0 → `ready` after `WAIT_STATES`+1 cycles, `MemData` equal to the preloaded word 0.
- Write then read: with `WAIT_STATES`=1, write 0xDEADBEEF to 0x10, then read 0x10 → `ready` 2 cycles after each accept, `MemData`=0xDEADBEEF, `misaligned`=0.
- Misaligned write: write 0x12345678 to 0x13 → `ready`=1 with `misaligned`=1. A subsequent read of 0x10 still returns 0xDEADBEEF.
- Wrap-around: with `DEPTH_WORDS`=256, write 0xA5A5A5A5 to 0x400 → a read of 0x000 returns 0xA5A5A5A5.
- Abort: start a write of 0xCAFEF00D to 0x20 with `WAIT_STATES`=3, and pulse `reset` low during WAIT → no `ready`, `busy`=0. A later read of 0x20 returns the prior value.
- Latency sweep: `WAIT_STATES` = 0 and 15 with back-to-back reads (`req` held high) → `ready` pulses spaced by 2 and 17 cycles respectively. Inputs changed after accept do not alter the result.
